// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: stage indices,
// stage-vector type, FSM state encoding and fixed stall/flush patterns.
package hazard_ctrl_pkg;

  localparam int unsigned NUM_STAGES = 9;
  localparam int unsigned PC_W       = 64;
  localparam int unsigned CNT_W      = 32;

  localparam int unsigned STG_IF   = 0;
  localparam int unsigned STG_IDC  = 1;
  localparam int unsigned STG_IDR  = 2;
  localparam int unsigned STG_EXB  = 3;
  localparam int unsigned STG_EXA  = 4;
  localparam int unsigned STG_EXC  = 5;
  localparam int unsigned STG_MEMP = 6;
  localparam int unsigned STG_MEMR = 7;
  localparam int unsigned STG_WB   = 8;

  typedef logic [NUM_STAGES-1:0] stage_vec_t;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_REDIRECT = 2'd2
  } hz_state_e;

  // Mask with bits [0 .. last] set, i.e. every stage up to and including 'last'.
  function automatic stage_vec_t stages_upto(input int unsigned last);
    stages_upto = stage_vec_t'((stage_vec_t'(1) << (last + 1)) - stage_vec_t'(1));
  endfunction

  function automatic stage_vec_t stage_bit(input int unsigned idx);
    stage_bit = stage_vec_t'(1) << idx;
  endfunction

  // Memory wait freezes IF..MEMP and bubbles MEMR so WB drains cleanly.
  localparam stage_vec_t MEMW_STALL  = stages_upto(STG_MEMP);
  localparam stage_vec_t MEMW_FLUSH  = stage_bit(STG_MEMR);
  // Redirect squashes the wrong-path instructions younger than EXC.
  localparam stage_vec_t REDIR_FLUSH = stages_upto(STG_EXA);
  localparam stage_vec_t LOAD_FLUSH  = stage_bit(STG_IF);
  // Unforwardable operand holds IF/IDC and bubbles IDR.
  localparam stage_vec_t DATA_STALL  = stages_upto(STG_IDC);
  localparam stage_vec_t DATA_FLUSH  = stage_bit(STG_IDR);

endpackage

// File: rtl/stall_watchdog.sv
// Saturating stall-cycle counter plus consecutive-stall watchdog with a
// sticky timeout flag.
module stall_watchdog
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned WDOG_LIMIT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic             stall_timeout_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] total_q;
  logic [CNT_W-1:0] consec_q;
  logic [CNT_W:0]   consec_inc;
  logic             limit_hit;

  assign consec_inc = {1'b0, consec_q} + (CNT_W+1)'(1);
  assign limit_hit  = stall && (consec_inc >= (CNT_W+1)'(WDOG_LIMIT));

  // Total stall cycles, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q <= '0;
    end else if (stall && (total_q != CNT_MAX)) begin
      total_q <= total_q + CNT_W'(1);
    end
  end

  // Consecutive run length; any non-stall cycle restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      consec_q <= '0;
    end else if (!stall) begin
      consec_q <= '0;
    end else if (consec_q != CNT_MAX) begin
      consec_q <= consec_inc[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_timeout_o <= 1'b0;
    end else if (limit_hit) begin
      stall_timeout_o <= 1'b1;
    end
  end

  assign stall_cycles_o = total_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: arbitrates memory wait, EXC redirects and
// data hazards into per-stage stall/flush vectors and a PC reload.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned WDOG_LIMIT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             no_forwarding_data,
  input  logic             mem_wait,
  input  logic             redirect_req,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic [8:0]       stall_o,
  output logic [8:0]       flush_o,
  output logic             pc_load_o,
  output logic [PC_W-1:0]  pc_target_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic             stall_timeout_o
);

  hz_state_e       state_q, state_d;
  stage_vec_t      stall_c, flush_c;
  logic            pc_load_c;
  logic            latch_c;
  logic [PC_W-1:0] pc_target_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Event arbitration: mem_wait > redirect > data hazard.
  always_comb begin
    state_d   = state_q;
    stall_c   = '0;
    flush_c   = '0;
    pc_load_c = 1'b0;
    latch_c   = 1'b0;

    case (state_q)
      ST_REDIRECT: begin
        // The PC load always completes; IF stays unstalled so it takes it.
        pc_load_c = 1'b1;
        flush_c   = LOAD_FLUSH;
        if (mem_wait) begin
          stall_c = MEMW_STALL & ~LOAD_FLUSH;
          flush_c = LOAD_FLUSH | MEMW_FLUSH;
          state_d = ST_MEM_WAIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        // RUN and MEM_WAIT share rules once mem_wait is low.
        if (mem_wait) begin
          stall_c = MEMW_STALL;
          flush_c = MEMW_FLUSH;
          state_d = ST_MEM_WAIT;
        end else if (redirect_req) begin
          flush_c = REDIR_FLUSH;
          latch_c = 1'b1;
          state_d = ST_REDIRECT;
        end else if (no_forwarding_data) begin
          stall_c = DATA_STALL;
          flush_c = DATA_FLUSH;
          state_d = ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end
    endcase

    if (!rst_n) begin
      stall_c   = '0;
      flush_c   = '1;
      pc_load_c = 1'b0;
      latch_c   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_target_q <= '0;
    end else if (latch_c) begin
      pc_target_q <= redirect_pc;
    end
  end

  stall_watchdog #(
    .WDOG_LIMIT(WDOG_LIMIT)
  ) u_stall_watchdog (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (|stall_c),
    .stall_cycles_o (stall_cycles_o),
    .stall_timeout_o(stall_timeout_o)
  );

  assign stall_o     = stall_c;
  assign flush_o     = flush_c;
  assign pc_load_o   = pc_load_c;
  assign pc_target_o = pc_target_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        no_forwarding_data;
  logic        mem_wait;
  logic        redirect_req;
  logic [63:0] redirect_pc;
  logic [8:0]  stall_o;
  logic [8:0]  flush_o;
  logic        pc_load_o;
  logic [63:0] pc_target_o;
  logic [31:0] stall_cycles_o;
  logic        stall_timeout_o;

  int total = 0;
  int bad   = 0;
  int unsigned exp_cycles = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.WDOG_LIMIT(255)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .no_forwarding_data(no_forwarding_data),
    .mem_wait          (mem_wait),
    .redirect_req      (redirect_req),
    .redirect_pc       (redirect_pc),
    .stall_o           (stall_o),
    .flush_o           (flush_o),
    .pc_load_o         (pc_load_o),
    .pc_target_o       (pc_target_o),
    .stall_cycles_o    (stall_cycles_o),
    .stall_timeout_o   (stall_timeout_o)
  );

  // Advance one clock; the bench model counts the cycle if it was a stall cycle.
  task automatic tick(input bit stalled);
    @(posedge clk);
    if (stalled) exp_cycles++;
    #1;
  endtask

  task automatic drive(input bit nfd, input bit mw, input bit rr, input logic [63:0] pc);
    no_forwarding_data = nfd;
    mem_wait           = mw;
    redirect_req       = rr;
    redirect_pc        = pc;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(0, 0, 0, 64'h0);
    total++; if (stall_o !== 9'h000) begin bad++; $display("FAIL rst_stall got %h want 000", stall_o); end
    total++; if (flush_o !== 9'h1FF) begin bad++; $display("FAIL rst_flush got %h want 1ff", flush_o); end
    total++; if (pc_load_o !== 1'b0) begin bad++; $display("FAIL rst_pcload got %b want 0", pc_load_o); end
    total++; if (pc_target_o !== 64'h0) begin bad++; $display("FAIL rst_target got %h want 0", pc_target_o); end
    total++; if (stall_cycles_o !== 32'h0) begin bad++; $display("FAIL rst_cycles got %0d want 0", stall_cycles_o); end
    total++; if (stall_timeout_o !== 1'b0) begin bad++; $display("FAIL rst_timeout got %b want 0", stall_timeout_o); end
    #5 rst_n = 1'b1;
    tick(0);
    total++; if (flush_o !== 9'h000 || stall_o !== 9'h000) begin bad++; $display("FAIL idle_out got s=%h f=%h want 000/000", stall_o, flush_o); end
  endtask

  task automatic test_data_hazard;
    drive(1, 0, 0, 64'h0);
    for (int c = 0; c < 2; c++) begin
      total++; if (stall_o !== 9'h003) begin bad++; $display("FAIL dh_stall c%0d got %h want 003", c, stall_o); end
      total++; if (flush_o !== 9'h004) begin bad++; $display("FAIL dh_flush c%0d got %h want 004", c, flush_o); end
      tick(1);
    end
    drive(0, 0, 0, 64'h0);
    total++; if (stall_o !== 9'h000 || flush_o !== 9'h000 || pc_load_o !== 1'b0) begin bad++; $display("FAIL dh_after got s=%h f=%h l=%b want 000/000/0", stall_o, flush_o, pc_load_o); end
    total++; if (stall_cycles_o !== exp_cycles) begin bad++; $display("FAIL dh_cycles got %0d want %0d", stall_cycles_o, exp_cycles); end
    tick(0);
  endtask

  task automatic test_redirect;
    drive(0, 0, 1, 64'h8000_0040);
    total++; if (flush_o !== 9'h01F || stall_o !== 9'h000) begin bad++; $display("FAIL rd_c1 got f=%h s=%h want 01f/000", flush_o, stall_o); end
    total++; if (pc_load_o !== 1'b0) begin bad++; $display("FAIL rd_c1_load got %b want 0", pc_load_o); end
    tick(0);
    drive(1, 0, 1, 64'h0);
    total++; if (pc_load_o !== 1'b1) begin bad++; $display("FAIL rd_c2_load got %b want 1", pc_load_o); end
    total++; if (pc_target_o !== 64'h8000_0040) begin bad++; $display("FAIL rd_c2_target got %h want 80000040", pc_target_o); end
    total++; if (flush_o !== 9'h001 || stall_o !== 9'h000) begin bad++; $display("FAIL rd_c2_vec got f=%h s=%h want 001/000", flush_o, stall_o); end
    tick(0);
    drive(0, 0, 0, 64'h0);
    total++; if (pc_load_o !== 1'b0 || flush_o !== 9'h000) begin bad++; $display("FAIL rd_c3 got l=%b f=%h want 0/000", pc_load_o, flush_o); end
    tick(0);
  endtask

  task automatic test_mem_then_redirect;
    drive(0, 1, 1, 64'h0000_1234_5678_9ABC);
    for (int c = 1; c <= 3; c++) begin
      total++; if (stall_o !== 9'h07F || flush_o !== 9'h080) begin bad++; $display("FAIL mr_wait c%0d got s=%h f=%h want 07f/080", c, stall_o, flush_o); end
      total++; if (pc_load_o !== 1'b0) begin bad++; $display("FAIL mr_wait_load c%0d got %b want 0", c, pc_load_o); end
      tick(1);
    end
    total++; if (pc_target_o !== 64'h8000_0040) begin bad++; $display("FAIL mr_nolatch got %h want 80000040", pc_target_o); end
    drive(0, 0, 1, 64'h0000_1234_5678_9ABC);
    total++; if (flush_o !== 9'h01F || stall_o !== 9'h000 || pc_load_o !== 1'b0) begin bad++; $display("FAIL mr_c4 got f=%h s=%h l=%b want 01f/000/0", flush_o, stall_o, pc_load_o); end
    tick(0);
    drive(0, 0, 0, 64'h0);
    total++; if (pc_load_o !== 1'b1 || pc_target_o !== 64'h0000_1234_5678_9ABC) begin bad++; $display("FAIL mr_c5 got l=%b t=%h want 1/123456789abc", pc_load_o, pc_target_o); end
    tick(0);
    total++; if (pc_load_o !== 1'b0) begin bad++; $display("FAIL mr_c6_load got %b want 0", pc_load_o); end
    total++; if (stall_cycles_o !== exp_cycles) begin bad++; $display("FAIL mr_cycles got %0d want %0d", stall_cycles_o, exp_cycles); end
  endtask

  task automatic test_mem_and_nfd;
    drive(1, 1, 0, 64'h0);
    for (int c = 1; c <= 3; c++) begin
      total++; if (stall_o !== 9'h07F || flush_o !== 9'h080) begin bad++; $display("FAIL mn_vec c%0d got s=%h f=%h want 07f/080", c, stall_o, flush_o); end
      tick(1);
      total++; if (stall_cycles_o !== exp_cycles) begin bad++; $display("FAIL mn_cycles c%0d got %0d want %0d", c, stall_cycles_o, exp_cycles); end
    end
    drive(0, 0, 0, 64'h0);
    tick(0);
  endtask

  task automatic test_redirect_then_mem;
    drive(0, 0, 1, 64'hFFFF_0000_0000_0100);
    tick(0);
    drive(0, 1, 0, 64'h0);
    total++; if (pc_load_o !== 1'b1) begin bad++; $display("FAIL rm_load got %b want 1", pc_load_o); end
    total++; if (stall_o !== 9'h07E || flush_o !== 9'h081) begin bad++; $display("FAIL rm_vec got s=%h f=%h want 07e/081", stall_o, flush_o); end
    tick(1);
    total++; if (pc_load_o !== 1'b0 || stall_o !== 9'h07F || flush_o !== 9'h080) begin bad++; $display("FAIL rm_next got l=%b s=%h f=%h want 0/07f/080", pc_load_o, stall_o, flush_o); end
    tick(1);
    drive(0, 0, 0, 64'h0);
    tick(0);
    total++; if (pc_load_o !== 1'b0 || stall_o !== 9'h000 || flush_o !== 9'h000) begin bad++; $display("FAIL rm_idle got l=%b s=%h f=%h want 0/000/000", pc_load_o, stall_o, flush_o); end
  endtask

  task automatic test_watchdog;
    drive(0, 1, 0, 64'h0);
    for (int c = 1; c <= 254; c++) tick(1);
    total++; if (stall_timeout_o !== 1'b0) begin bad++; $display("FAIL wd_254 got %b want 0", stall_timeout_o); end
    tick(1);
    total++; if (stall_timeout_o !== 1'b1) begin bad++; $display("FAIL wd_255 got %b want 1", stall_timeout_o); end
    drive(0, 0, 0, 64'h0);
    tick(0);
    tick(0);
    total++; if (stall_timeout_o !== 1'b1) begin bad++; $display("FAIL wd_sticky got %b want 1", stall_timeout_o); end
    total++; if (stall_cycles_o !== exp_cycles) begin bad++; $display("FAIL wd_cycles got %0d want %0d", stall_cycles_o, exp_cycles); end
  endtask

  task automatic test_reset_in_redirect;
    drive(0, 0, 1, 64'h8000_0080);
    tick(0);
    drive(0, 0, 0, 64'h0);
    total++; if (pc_load_o !== 1'b1) begin bad++; $display("FAIL rr_pre got %b want 1", pc_load_o); end
    #1 rst_n = 1'b0;
    exp_cycles = 0;
    #1;
    total++; if (pc_load_o !== 1'b0 || flush_o !== 9'h1FF || stall_o !== 9'h000) begin bad++; $display("FAIL rr_out got l=%b f=%h s=%h want 0/1ff/000", pc_load_o, flush_o, stall_o); end
    total++; if (stall_cycles_o !== 32'h0 || stall_timeout_o !== 1'b0 || pc_target_o !== 64'h0) begin bad++; $display("FAIL rr_regs got c=%0d t=%b p=%h want 0/0/0", stall_cycles_o, stall_timeout_o, pc_target_o); end
    tick(0);
    rst_n = 1'b1;
    tick(0);
    total++; if (pc_load_o !== 1'b0 || flush_o !== 9'h000) begin bad++; $display("FAIL rr_after got l=%b f=%h want 0/000", pc_load_o, flush_o); end
  endtask

  initial begin
    test_reset;
    test_data_hazard;
    test_redirect;
    test_mem_then_redirect;
    test_mem_and_nfd;
    test_redirect_then_mem;
    test_watchdog;
    test_reset_in_redirect;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
